// File: rtl/moore_seq_ctrl_if.sv
// Bundle between the sequencer, its config/result side and the Moore datapath.
// The slave modport is the sequencer's view; master is the surrounding tile or bench.
interface moore_seq_ctrl_if #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 4,
   parameter int DIV_W = 4
);
   localparam int LEN_W = $clog2(PAT_W + 1);

   logic             start;
   logic             abort;
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] len;
   logic [DIV_W-1:0] step_div;
   logic             z1;
   logic [2:0]       y;
   logic             x1;
   logic             fsm_clr;
   logic             fsm_step;
   logic             busy;
   logic             done;
   logic [PAT_W-1:0] z1_trace;
   logic [CNT_W-1:0] hit_count;
   logic [2:0]       final_y;

   modport slave (
      input  start, abort, pattern, len, step_div, z1, y,
      output x1, fsm_clr, fsm_step, busy, done, z1_trace, hit_count, final_y
   );

   modport master (
      output start, abort, pattern, len, step_div, z1, y,
      input  x1, fsm_clr, fsm_step, busy, done, z1_trace, hit_count, final_y
   );
endinterface

// File: rtl/moore_seq_ctrl.sv
// Clears the Moore machine, feeds a pattern into x1 LSB first and records z1 per step.
// Each step takes step_div+2 cycles; done pulses 2+len*(step_div+2) cycles after start.
module moore_seq_ctrl #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 4,
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   moore_seq_ctrl_if.slave  ctl
);
   localparam int LEN_W = $clog2(PAT_W + 1);
   localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_DRIVE, S_SAMPLE, S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [PAT_W-1:0] trace_q, trace_d;
   logic [CNT_W-1:0] hit_q, hit_d;
   logic [2:0]       fy_q, fy_d;

   logic x1, fsm_clr, fsm_step, busy, done;
   logic [IDX_W-1:0] last_eff;

   // Zero or oversize lengths run the full pattern; only the last index is kept.
   assign last_eff = (ctl.len == '0 || ctl.len > LEN_MAX) ? IDX_W'(PAT_W - 1)
                                                         : IDX_W'(ctl.len - 1'b1);

   always_comb begin
      state_d  = state_q;
      pat_d    = pat_q;
      last_d   = last_q;
      idx_d    = idx_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      trace_d  = trace_q;
      hit_d    = hit_q;
      fy_d     = fy_q;
      x1       = 1'b0;
      fsm_clr  = 1'b0;
      fsm_step = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ctl.start && !ctl.abort) begin
               pat_d   = ctl.pattern;
               last_d  = last_eff;
               div_d   = ctl.step_div;
               trace_d = '0;
               hit_d   = '0;
               idx_d   = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            fsm_clr = 1'b1;
            busy    = 1'b1;
            cnt_d   = div_q;
            state_d = ctl.abort ? S_IDLE : S_DRIVE;
         end
         S_DRIVE: begin
            busy = 1'b1;
            x1   = pat_q[idx_q];
            if (cnt_q == '0) begin
               fsm_step = 1'b1;
               state_d  = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
            if (ctl.abort) state_d = S_IDLE;
         end
         S_SAMPLE: begin
            // Capture still happens on an aborted step so the partial trace is usable.
            busy           = 1'b1;
            x1             = pat_q[idx_q];
            trace_d[idx_q] = ctl.z1;
            if (ctl.z1 && hit_q != '1) hit_d = hit_q + 1'b1;
            if (idx_q == last_q) begin
               fy_d    = ctl.y;
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               cnt_d   = div_q;
               state_d = S_DRIVE;
            end
            if (ctl.abort) state_d = S_IDLE;
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         last_q  <= '0;
         idx_q   <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         trace_q <= '0;
         hit_q   <= '0;
         fy_q    <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         trace_q <= trace_d;
         hit_q   <= hit_d;
         fy_q    <= fy_d;
      end
   end

   assign ctl.x1        = x1;
   assign ctl.fsm_clr   = fsm_clr;
   assign ctl.fsm_step  = fsm_step;
   assign ctl.busy      = busy;
   assign ctl.done      = done;
   assign ctl.z1_trace  = trace_q;
   assign ctl.hit_count = hit_q;
   assign ctl.final_y   = fy_q;
endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Bench for moore_seq_ctrl: two instances (4-bit and 2-bit hit counters) share stimulus;
// a stub Moore machine registers x1 into z1 and a 3-bit history into y on each step.
module tb_moore_seq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   moore_seq_ctrl_if #(.PAT_W(8), .CNT_W(4), .DIV_W(4)) b1 ();
   moore_seq_ctrl_if #(.PAT_W(8), .CNT_W(2), .DIV_W(4)) b2 ();

   moore_seq_ctrl #(.PAT_W(8), .CNT_W(4), .DIV_W(4)) u_dut  (.clk(clk), .rst(rst), .ctl(b1.slave));
   moore_seq_ctrl #(.PAT_W(8), .CNT_W(2), .DIV_W(4)) u_dut2 (.clk(clk), .rst(rst), .ctl(b2.slave));

   assign b2.start    = b1.start;
   assign b2.abort    = b1.abort;
   assign b2.pattern  = b1.pattern;
   assign b2.len      = b1.len;
   assign b2.step_div = b1.step_div;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b1.z1 <= 1'b0; b1.y <= 3'd0;
      end else if (b1.fsm_clr) begin
         b1.z1 <= 1'b0; b1.y <= 3'd0;
      end else if (b1.fsm_step) begin
         b1.z1 <= b1.x1; b1.y <= {b1.y[1:0], b1.x1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b2.z1 <= 1'b0; b2.y <= 3'd0;
      end else if (b2.fsm_clr) begin
         b2.z1 <= 1'b0; b2.y <= 3'd0;
      end else if (b2.fsm_step) begin
         b2.z1 <= b2.x1; b2.y <= {b2.y[1:0], b2.x1};
      end
   end

   typedef struct {
      logic [7:0] trace;
      logic [3:0] hits;
      logic [1:0] hits2;
      logic [2:0] fy;
      int         lat;
      int         steps;
      int         gap;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int n_chk = 0, n_pass = 0, n_push = 0, n_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
   endtask

   function automatic exp_t model(input logic [7:0] p, input logic [3:0] l, input logic [3:0] sd);
      exp_t e;
      int le;
      int pop;
      le = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
      pop = 0;
      e.trace = 8'h00;
      e.fy = 3'd0;
      for (int i = 0; i < le; i++) begin
         e.trace[i] = p[i];
         e.fy = {e.fy[1:0], p[i]};
         if (p[i]) pop++;
      end
      e.hits  = 4'(pop);
      e.hits2 = (pop > 3) ? 2'd3 : 2'(pop);
      e.lat   = le * (int'(sd) + 2) + 2;
      e.steps = le;
      e.gap   = int'(sd) + 2;
      return e;
   endfunction

   // Monitor: per-run activity counters, popped against the scoreboard on done.
   int busy_cnt = 0, clr_n = 0, clr_at = 0, step_n = 0, since = 0, gap_min = 0, gap_max = 0;
   bit prev_done = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt = 0; clr_n = 0; step_n = 0; prev_done = 1'b0;
      end else begin
         if (prev_done) chk("done_one_cycle", b1.done, 0);
         prev_done = b1.done;
         if (b1.busy) busy_cnt++;
         else begin busy_cnt = 0; clr_n = 0; end
         since++;
         if (b1.fsm_clr) begin
            clr_n++; clr_at = busy_cnt; step_n = 0; gap_min = 9999; gap_max = 0;
         end
         if (b1.fsm_step) begin
            if (step_n > 0) begin
               if (since < gap_min) gap_min = since;
               if (since > gap_max) gap_max = since;
            end
            since = 0;
            step_n++;
         end
         if (b1.done) begin
            n_done++;
            chk("done_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               mon_e = sb.pop_front();
               chk("z1_trace", b1.z1_trace, mon_e.trace);
               chk("hit_count", b1.hit_count, mon_e.hits);
               chk("hit_count_sat", b2.hit_count, mon_e.hits2);
               chk("final_y", b1.final_y, mon_e.fy);
               chk("done_latency", busy_cnt, mon_e.lat);
               chk("step_count", step_n, mon_e.steps);
               chk("clr_count", clr_n, 1);
               chk("clr_first_busy", clr_at, 1);
               chk("dut2_done", b2.done, 1);
               if (mon_e.steps > 1) begin
                  chk("step_gap_min", gap_min, mon_e.gap);
                  chk("step_gap_max", gap_max, mon_e.gap);
               end
            end
         end
      end
   end

   task automatic run(input logic [7:0] p, input logic [3:0] l, input logic [3:0] sd, input bit push);
      @(negedge clk);
      b1.pattern  = p;
      b1.len      = l;
      b1.step_div = sd;
      b1.start    = 1'b1;
      if (push) begin
         sb.push_back(model(p, l, sd));
         n_push++;
      end
      @(negedge clk);
      b1.start = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", sb.size(), 0);
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_x1"}, b1.x1, 0);
      chk({tag, "_fsm_clr"}, b1.fsm_clr, 0);
      chk({tag, "_fsm_step"}, b1.fsm_step, 0);
      chk({tag, "_busy"}, b1.busy, 0);
      chk({tag, "_done"}, b1.done, 0);
      chk({tag, "_trace"}, b1.z1_trace, 0);
      chk({tag, "_hits"}, b1.hit_count, 0);
      chk({tag, "_final_y"}, b1.final_y, 0);
      chk({tag, "_hits2"}, b2.hit_count, 0);
   endtask

   initial begin
      b1.start = 1'b0; b1.abort = 1'b0; b1.pattern = 8'h00; b1.len = 4'd0; b1.step_div = 4'd0;
      #1;
      chk_all_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run(8'hB2, 4'd8, 4'd0, 1'b1); drain();
      run(8'h01, 4'd3, 4'd3, 1'b1); drain();

      // Second start while busy must be dropped.
      run(8'h5A, 4'd0, 4'd0, 1'b1);
      repeat (4) @(negedge clk);
      b1.pattern = 8'hFF; b1.len = 4'd2; b1.start = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
      drain();
      repeat (25) @(negedge clk);
      chk("t3_idle_after", b1.busy, 0);

      run(8'hFF, 4'd8, 4'd0, 1'b1); drain();
      run(8'h3C, 4'd12, 4'd1, 1'b1); drain();
      run(8'h01, 4'd1, 4'd0, 1'b1); drain();

      // Abort during the third SAMPLE of an 8-step run.
      run(8'h6D, 4'd8, 4'd0, 1'b0);
      repeat (6) @(negedge clk);
      b1.abort = 1'b1;
      @(negedge clk);
      chk("abort_busy", b1.busy, 0);
      chk("abort_x1", b1.x1, 0);
      chk("abort_step", b1.fsm_step, 0);
      chk("abort_trace", b1.z1_trace, 8'h05);
      chk("abort_hits", b1.hit_count, 2);
      chk("abort_hits2", b2.hit_count, 2);
      b1.abort = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_still_idle", b1.busy, 0);
      chk("abort_trace_held", b1.z1_trace, 8'h05);

      // start with abort in IDLE is ignored.
      b1.start = 1'b1; b1.abort = 1'b1;
      @(negedge clk);
      chk("idle_abort_busy", b1.busy, 0);
      chk("idle_abort_clr", b1.fsm_clr, 0);
      b1.start = 1'b0; b1.abort = 1'b0;

      // Asynchronous reset in the middle of DRIVE.
      run(8'hA5, 4'd8, 4'd2, 1'b0);
      @(negedge clk);
      chk("pre_rst_busy", b1.busy, 1);
      #2 rst = 1'b1;
      #1 chk_all_zero("midrun_rst");
      @(negedge clk);
      rst = 1'b0;

      run(8'hC3, 4'd5, 4'd1, 1'b1); drain();
      repeat (5) @(negedge clk);
      chk("done_count", n_done, n_push);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
